// File: rtl/gpio_mmio.sv
// Memory-mapped GPIO peripheral: output data/enable registers, synchronised inputs,
// atomic set/clear/toggle and edge-detect interrupts with sticky write-1-to-clear status.
module gpio_mmio #(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] OUT_RESET   = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sel_in,
  input  logic [31:0]      address_in,
  input  logic [3:0]       write_mask_in,
  input  logic [31:0]      write_value_in,
  output logic [31:0]      read_value_out,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq_out
);

  localparam logic [2:0] WARM_DONE = 3'(SYNC_STAGES + 1);

  localparam logic [3:0] REG_DATA_OUT   = 4'h0;
  localparam logic [3:0] REG_DIR        = 4'h1;
  localparam logic [3:0] REG_DATA_IN    = 4'h2;
  localparam logic [3:0] REG_SET        = 4'h3;
  localparam logic [3:0] REG_CLEAR      = 4'h4;
  localparam logic [3:0] REG_TOGGLE     = 4'h5;
  localparam logic [3:0] REG_RISE_EN    = 4'h6;
  localparam logic [3:0] REG_FALL_EN    = 4'h7;
  localparam logic [3:0] REG_IRQ_STATUS = 4'h8;

  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] irq_status_q, irq_status_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [2:0]       warm_cnt_q, warm_cnt_d;
  logic [31:0]      read_value_q, read_value_d;

  logic [31:0]      lane_mask;
  logic [31:0]      wdata_masked;
  logic [WIDTH-1:0] wr_mask;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] edge_event;
  logic [WIDTH-1:0] w1c;
  logic             wr_en;
  logic             warm_done;
  logic             unused_bits;

  // Bus: sel_in qualifies a single-cycle operation with no back-pressure; a non-zero
  // write_mask_in makes it a write, and read data is registered for the following cycle.
  assign lane_mask = {{8{write_mask_in[3]}}, {8{write_mask_in[2]}},
                      {8{write_mask_in[1]}}, {8{write_mask_in[0]}}};
  assign wdata_masked = write_value_in & lane_mask;
  assign wr_mask      = lane_mask[WIDTH-1:0];
  assign wr_data      = wdata_masked[WIDTH-1:0];
  assign wr_en        = sel_in & (|write_mask_in);
  assign sync_in      = sync_q[SYNC_STAGES-1];
  assign warm_done    = (warm_cnt_q == WARM_DONE);
  assign unused_bits  = ^{address_in[31:6], address_in[1:0], wdata_masked};

  // Edges are ignored until the synchroniser has flushed its post-reset contents.
  assign edge_event = warm_done ? ((sync_in & ~prev_q & rise_en_q) |
                                   (~sync_in & prev_q & fall_en_q)) : '0;

  always_comb begin
    read_value_d = '0;
    if (sel_in) begin
      case (address_in[5:2])
        REG_DATA_OUT:   read_value_d[WIDTH-1:0] = data_out_q;
        REG_DIR:        read_value_d[WIDTH-1:0] = dir_q;
        REG_DATA_IN:    read_value_d[WIDTH-1:0] = sync_in;
        REG_RISE_EN:    read_value_d[WIDTH-1:0] = rise_en_q;
        REG_FALL_EN:    read_value_d[WIDTH-1:0] = fall_en_q;
        REG_IRQ_STATUS: read_value_d[WIDTH-1:0] = irq_status_q;
        default:        read_value_d = '0;
      endcase
    end
  end

  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    w1c        = '0;
    if (wr_en) begin
      case (address_in[5:2])
        REG_DATA_OUT:   data_out_d = (data_out_q & ~wr_mask) | wr_data;
        REG_DIR:        dir_d      = (dir_q & ~wr_mask) | wr_data;
        REG_SET:        data_out_d = data_out_q | wr_data;
        REG_CLEAR:      data_out_d = data_out_q & ~wr_data;
        REG_TOGGLE:     data_out_d = data_out_q ^ wr_data;
        REG_RISE_EN:    rise_en_d  = (rise_en_q & ~wr_mask) | wr_data;
        REG_FALL_EN:    fall_en_d  = (fall_en_q & ~wr_mask) | wr_data;
        REG_IRQ_STATUS: w1c        = wr_data;
        default:        ;
      endcase
    end
    // A new event outranks a simultaneous clear of the same bit.
    irq_status_d = (irq_status_q & ~w1c) | edge_event;
    warm_cnt_d   = warm_done ? warm_cnt_q : warm_cnt_q + 3'd1;
    prev_d       = sync_in;
  end

  always_comb begin
    sync_d[0] = gpio_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q   <= OUT_RESET;
      dir_q        <= '0;
      rise_en_q    <= '0;
      fall_en_q    <= '0;
      irq_status_q <= '0;
      prev_q       <= '0;
      warm_cnt_q   <= '0;
      read_value_q <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      data_out_q   <= data_out_d;
      dir_q        <= dir_d;
      rise_en_q    <= rise_en_d;
      fall_en_q    <= fall_en_d;
      irq_status_q <= irq_status_d;
      prev_q       <= prev_d;
      warm_cnt_q   <= warm_cnt_d;
      read_value_q <= read_value_d;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign read_value_out = read_value_q;
  assign gpio_out       = data_out_q;
  assign gpio_oe        = dir_q;
  assign irq_out        = |irq_status_q;

endmodule

// File: tb/tb_gpio_mmio.sv
// Bench for gpio_mmio: directed register/interrupt scenarios plus randomized bus and pin
// traffic, all compared against a register-level reference model with a pin-history queue.
module tb_gpio_mmio;

  localparam int W = 8;
  localparam int S = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          sel_in;
  logic [31:0]   address_in;
  logic [3:0]    write_mask_in;
  logic [31:0]   write_value_in;
  logic [31:0]   read_value_out;
  logic [W-1:0]  gpio_in;
  logic [W-1:0]  gpio_out;
  logic [W-1:0]  gpio_oe;
  logic          irq_out;

  always #5 clk = ~clk;

  gpio_mmio #(.WIDTH(W), .SYNC_STAGES(S), .OUT_RESET(8'h00)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .sel_in         (sel_in),
    .address_in     (address_in),
    .write_mask_in  (write_mask_in),
    .write_value_in (write_value_in),
    .read_value_out (read_value_out),
    .gpio_in        (gpio_in),
    .gpio_out       (gpio_out),
    .gpio_oe        (gpio_oe),
    .irq_out        (irq_out)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: register contents plus a history of pin samples per clock edge.
  logic [W-1:0] m_out, m_dir, m_rise, m_fall, m_stat;
  logic [W-1:0] hist[$];
  int           m_n;
  logic [31:0]  exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ref_reset();
    m_out  = 8'h00;
    m_dir  = '0;
    m_rise = '0;
    m_fall = '0;
    m_stat = '0;
    m_n    = 0;
    hist.delete();
    repeat (S + 1) hist.push_back('0);
    exp_q.delete();
  endtask

  // hist[0] is the previous synchronised sample, hist[1] the current one.
  function automatic logic [31:0] ref_read(input logic [3:0] idx);
    logic [31:0] r;
    r = '0;
    case (idx)
      4'h0: r[W-1:0] = m_out;
      4'h1: r[W-1:0] = m_dir;
      4'h2: r[W-1:0] = hist[1];
      4'h6: r[W-1:0] = m_rise;
      4'h7: r[W-1:0] = m_fall;
      4'h8: r[W-1:0] = m_stat;
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic ref_edge();
    logic [31:0]  wd;
    logic [W-1:0] wv, wm, ev, clr, cur, old;
    wd = '0;
    for (int k = 0; k < 4; k++) begin
      if (write_mask_in[k]) wd[8*k +: 8] = write_value_in[8*k +: 8];
    end
    wv  = wd[W-1:0];
    wm  = '0;
    for (int b = 0; b < W; b++) wm[b] = write_mask_in[b / 8];
    cur = hist[1];
    old = hist[0];
    ev  = '0;
    if (m_n >= S + 1) begin
      for (int b = 0; b < W; b++) begin
        if (cur[b] && !old[b] && m_rise[b]) ev[b] = 1'b1;
        if (!cur[b] && old[b] && m_fall[b]) ev[b] = 1'b1;
      end
    end
    exp_q.push_back(sel_in ? ref_read(address_in[5:2]) : 32'h0);
    clr = '0;
    if (sel_in && write_mask_in != 4'h0) begin
      case (address_in[5:2])
        4'h0: m_out  = (m_out & ~wm) | wv;
        4'h1: m_dir  = (m_dir & ~wm) | wv;
        4'h3: m_out  = m_out | wv;
        4'h4: m_out  = m_out & ~wv;
        4'h5: m_out  = m_out ^ wv;
        4'h6: m_rise = (m_rise & ~wm) | wv;
        4'h7: m_fall = (m_fall & ~wm) | wv;
        4'h8: clr    = wv;
        default: ;
      endcase
    end
    m_stat = (m_stat & ~clr) | ev;
    hist.push_back(gpio_in);
    void'(hist.pop_front());
    if (m_n < 1000) m_n++;
  endtask

  // One clock with the currently driven inputs; entered and left at a falling edge.
  task automatic step();
    ref_edge();
    @(posedge clk);
    #1;
    check("read_value", read_value_out, exp_q.pop_front());
    check("gpio_out", gpio_out, m_out);
    check("gpio_oe", gpio_oe, m_dir);
    check("irq_out", irq_out, |m_stat);
    @(negedge clk);
  endtask

  task automatic bus(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    sel_in         = 1'b1;
    address_in     = a;
    write_mask_in  = m;
    write_value_in = d;
    step();
    sel_in         = 1'b0;
    address_in     = '0;
    write_mask_in  = '0;
    write_value_in = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    ref_reset();
    repeat (2) @(negedge clk);
    check("rst_gpio_out", gpio_out, 8'h00);
    check("rst_gpio_oe", gpio_oe, 8'h00);
    check("rst_irq", irq_out, 1'b0);
    check("rst_read", read_value_out, 32'h0);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n        = 1'b0;
    sel_in         = 1'b0;
    address_in     = '0;
    write_mask_in  = '0;
    write_value_in = '0;
    gpio_in        = '0;
    @(negedge clk);
    do_reset();

    bus(32'h00, 4'h0, 32'h0);
    check("t1_read0", read_value_out, 32'h0);

    bus(32'h00, 4'hF, 32'hA5);
    check("t2_write", gpio_out, 8'hA5);
    bus(32'h0C, 4'hF, 32'h0F);
    check("t2_set", gpio_out, 8'hAF);
    bus(32'h10, 4'hF, 32'h81);
    check("t2_clear", gpio_out, 8'h2E);
    bus(32'h14, 4'hF, 32'hFF);
    check("t2_toggle", gpio_out, 8'hD1);
    bus(32'h00, 4'b0001, 32'h1234);
    check("t2_lane0", gpio_out, 8'h34);
    bus(32'h00, 4'b0010, 32'hFF);
    check("t2_lane_off", gpio_out, 8'h34);
    bus(32'h04, 4'hF, 32'h5A);
    check("t2_dir", gpio_oe, 8'h5A);
    bus(32'h04, 4'h0, 32'h0);
    check("t2_dir_rd", read_value_out, 32'h5A);

    bus(32'h18, 4'hF, 32'h01);
    repeat (4) step();
    gpio_in = 8'h01;
    step();
    step();
    check("t3_irq_early", irq_out, 1'b0);
    bus(32'h08, 4'h0, 32'h0);
    check("t3_data_in", read_value_out, 32'h01);
    check("t3_irq", irq_out, 1'b1);
    bus(32'h20, 4'h0, 32'h0);
    check("t3_status", read_value_out, 32'h01);
    bus(32'h20, 4'h1, 32'h01);
    check("t3_w1c", irq_out, 1'b0);

    bus(32'h1C, 4'hF, 32'h02);
    gpio_in = 8'h03;
    repeat (4) step();
    check("t4_no_rise", irq_out, 1'b0);
    gpio_in = 8'h01;
    step();
    step();
    bus(32'h20, 4'h1, 32'h02);
    check("t4_set_wins", irq_out, 1'b1);
    bus(32'h1C, 4'hF, 32'h00);
    bus(32'h20, 4'h0, 32'h0);
    check("t4_sticky", read_value_out, 32'h02);
    bus(32'h20, 4'h1, 32'h02);
    check("t4_cleared", irq_out, 1'b0);

    gpio_in = 8'hFF;
    do_reset();
    bus(32'h18, 4'hF, 32'hFF);
    repeat (6) step();
    bus(32'h20, 4'h0, 32'h0);
    check("t5_status", read_value_out, 32'h0);
    check("t5_irq", irq_out, 1'b0);

    bus(32'h3C, 4'h0, 32'h0);
    check("t6_unmapped_rd", read_value_out, 32'h0);
    bus(32'h24, 4'hF, 32'hFFFF_FFFF);
    check("t6_unmapped_wr", gpio_out, 8'h00);
    bus(32'h0C, 4'hF, 32'h3C);
    sel_in        = 1'b1;
    address_in    = 32'h00;
    write_mask_in = 4'h0;
    step();
    check("t6_pre_reset", read_value_out, 32'h3C);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_reset_rd", read_value_out, 32'h0);
    check("t6_reset_out", gpio_out, 8'h00);
    sel_in = 1'b0;
    do_reset();

    bus(32'h18, 4'hF, $urandom);
    bus(32'h1C, 4'hF, $urandom);
    bus(32'h04, 4'hF, $urandom);
    for (int i = 0; i < 400; i++) begin
      sel_in              = ($urandom_range(0, 3) != 0);
      address_in          = $urandom;
      address_in[5:2]     = 4'($urandom_range(0, 9));
      write_mask_in       = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      write_value_in      = $urandom;
      if ($urandom_range(0, 2) == 0) gpio_in = W'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
